// File: rtl/vga_fetch_ctrl.sv
// Burst-read scheduler feeding a two-bank ping-pong line buffer for the VGA pixel path.
// Optional late frame-start counter enabled by defining VGA_FETCH_LATE_CNT_EN.
module vga_fetch_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         enable_i,
  input  logic [ADDR_WIDTH-1:0]        base_addr_i,
  input  logic [ADDR_WIDTH-1:0]        top_addr_i,
  input  logic                         frame_start_i,
  output logic                         rd_req_o,
  output logic [ADDR_WIDTH-1:0]        rd_addr_o,
  output logic [$clog2(BURST_LEN)-1:0] rd_len_o,
  input  logic                         rd_gnt_i,
  input  logic                         rd_valid_i,
  input  logic [DATA_WIDTH-1:0]        rd_data_i,
  input  logic                         rd_last_i,
  output logic                         wr_en_o,
  output logic                         wr_bank_o,
  output logic [$clog2(BURST_LEN)-1:0] wr_idx_o,
  output logic [DATA_WIDTH-1:0]        wr_data_o,
  input  logic [1:0]                   buf_release_i,
  output logic [1:0]                   bank_full_o,
  output logic                         frame_done_o,
  output logic                         cfg_err_o,
  output logic [15:0]                  late_cnt_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int LW    = $clog2(BURST_LEN);

  typedef enum logic [1:0] {IDLE, WAIT_BANK, REQ, DATA} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] top_q, cur_q;
  logic [LW-1:0]         len_q, beat_q;
  logic                  wr_bank_q;
  logic [1:0]            bank_full_q;
  logic                  frame_done_q;
  logic                  cfg_err_q;

  logic                  start, win_err, beat_last, frame_end;
  logic [ADDR_WIDTH-1:0] rem_words, cur_next;
  logic [LW-1:0]         req_len;
  logic [1:0]            set_mask;

  always_comb begin
    start     = enable_i && frame_start_i;
    // top <= base is an empty window even though the unsigned difference wraps large
    win_err   = (top_addr_i <= base_addr_i) ||
                ((top_addr_i - base_addr_i) < ADDR_WIDTH'(BYTES));
    rem_words = (top_q - cur_q) >> BSH;
    req_len   = (rem_words >= ADDR_WIDTH'(BURST_LEN)) ? '1 : (rem_words[LW-1:0] - LW'(1));
    cur_next  = cur_q + ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << BSH);
    frame_end = (top_q - cur_next) < ADDR_WIDTH'(BYTES);
    beat_last = (state_q == DATA) && rd_valid_i && rd_last_i;
    set_mask  = beat_last ? (wr_bank_q ? 2'b10 : 2'b01) : 2'b00;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start && !win_err) state_d = WAIT_BANK;
      end
      WAIT_BANK: begin
        if (!enable_i)                    state_d = IDLE;
        else if (!bank_full_q[wr_bank_q]) state_d = REQ;
      end
      REQ: begin
        if (!enable_i)     state_d = IDLE;
        else if (rd_gnt_i) state_d = DATA;
      end
      DATA: begin
        if (beat_last) begin
          if (frame_end || !enable_i) state_d = IDLE;
          else                        state_d = WAIT_BANK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_req_o  = 1'b0;
    rd_addr_o = '0;
    rd_len_o  = '0;
    wr_en_o   = 1'b0;
    wr_idx_o  = '0;
    wr_data_o = '0;
    // request is gated by enable so a dropped enable never coincides with a live request
    if (state_q == REQ && enable_i) begin
      rd_req_o  = 1'b1;
      rd_addr_o = cur_q;
      rd_len_o  = req_len;
    end
    if (state_q == DATA) begin
      wr_en_o   = rd_valid_i;
      wr_idx_o  = beat_q;
      wr_data_o = rd_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      top_q        <= '0;
      cur_q        <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      wr_bank_q    <= 1'b0;
      bank_full_q  <= '0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= 1'b0;
      // set wins over a same-cycle release on the same bank
      bank_full_q  <= (bank_full_q & ~buf_release_i) | set_mask;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            top_q     <= top_addr_i;
            cur_q     <= base_addr_i;
            cfg_err_q <= win_err;
          end
        end
        REQ: begin
          if (enable_i && rd_gnt_i) begin
            len_q  <= req_len;
            beat_q <= '0;
          end
        end
        DATA: begin
          if (rd_valid_i) beat_q <= beat_q + LW'(1);
          if (beat_last) begin
            wr_bank_q    <= ~wr_bank_q;
            cur_q        <= cur_next;
            frame_done_q <= frame_end;
          end
        end
        default: ;
      endcase
    end
  end

  assign wr_bank_o    = wr_bank_q;
  assign bank_full_o  = bank_full_q;
  assign frame_done_o = frame_done_q;
  assign cfg_err_o    = cfg_err_q;

`ifdef VGA_FETCH_LATE_CNT_EN
  logic [15:0] late_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      late_q <= '0;
    end else if (frame_start_i && enable_i && state_q != IDLE && late_q != '1) begin
      late_q <= late_q + 16'd1;
    end
  end

  assign late_cnt_o = late_q;
`else
  assign late_cnt_o = '0;
`endif

endmodule

// File: tb/tb_vga_fetch_ctrl.sv
// Randomized directed bench for vga_fetch_ctrl; expected bursts come from a window-splitting model.
module tb_vga_fetch_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [31:0] top_addr_i = '0;
  logic        frame_start_i = 1'b0;
  logic        rd_req_o;
  logic [31:0] rd_addr_o;
  logic [3:0]  rd_len_o;
  logic        rd_gnt_i = 1'b0;
  logic        rd_valid_i = 1'b0;
  logic [31:0] rd_data_i = '0;
  logic        rd_last_i = 1'b0;
  logic        wr_en_o;
  logic        wr_bank_o;
  logic [3:0]  wr_idx_o;
  logic [31:0] wr_data_o;
  logic [1:0]  buf_release_i = '0;
  logic [1:0]  bank_full_o;
  logic        frame_done_o;
  logic        cfg_err_o;
  logic [15:0] late_cnt_o;

  vga_fetch_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN(16)) dut (
    .clk(clk), .resetn(resetn), .enable_i(enable_i),
    .base_addr_i(base_addr_i), .top_addr_i(top_addr_i), .frame_start_i(frame_start_i),
    .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_len_o(rd_len_o), .rd_gnt_i(rd_gnt_i),
    .rd_valid_i(rd_valid_i), .rd_data_i(rd_data_i), .rd_last_i(rd_last_i),
    .wr_en_o(wr_en_o), .wr_bank_o(wr_bank_o), .wr_idx_o(wr_idx_o), .wr_data_o(wr_data_o),
    .buf_release_i(buf_release_i), .bank_full_o(bank_full_o), .frame_done_o(frame_done_o),
    .cfg_err_o(cfg_err_o), .late_cnt_o(late_cnt_o)
  );

  always #5 clk = ~clk;

`ifdef VGA_FETCH_LATE_CNT_EN
  localparam bit LATE_EN = 1'b1;
`else
  localparam bit LATE_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    int unsigned len;
  } burst_t;

  burst_t      exp_q[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic        exp_bank = 1'b0;
  logic [1:0]  exp_full = '0;
  int unsigned exp_late = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Split [base, top) into word bursts of at most 16; returns 1 for an unusable window.
  function automatic bit build_model(input logic [31:0] base, input logic [31:0] top);
    logic [31:0] cur;
    int unsigned words;
    int unsigned n;
    exp_q.delete();
    if (top <= base || (top - base) < 4) return 1'b1;
    cur = base;
    while ((top - cur) >= 4) begin
      words = (top - cur) / 4;
      n = (words > 16) ? 16 : words;
      exp_q.push_back('{addr: cur, len: n - 1});
      cur = cur + n * 4;
    end
    return 1'b0;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_req"}, rd_req_o, 0);
    chk({tag, "_rd_addr"}, rd_addr_o, 0);
    chk({tag, "_rd_len"}, rd_len_o, 0);
    chk({tag, "_wr_en"}, wr_en_o, 0);
    chk({tag, "_wr_bank"}, wr_bank_o, 0);
    chk({tag, "_wr_idx"}, wr_idx_o, 0);
    chk({tag, "_wr_data"}, wr_data_o, 0);
    chk({tag, "_bank_full"}, bank_full_o, 0);
    chk({tag, "_frame_done"}, frame_done_o, 0);
    chk({tag, "_cfg_err"}, cfg_err_o, 0);
    chk({tag, "_late_cnt"}, late_cnt_o, 0);
  endtask

  // norel: leave the first two banks full to exercise the stall; gd < 0 picks a random grant delay
  task automatic run_frame(input logic [31:0] base, input logic [31:0] top,
                           input bit norel, input int gd, input int late);
    bit          err;
    int          cyc;
    int          delay;
    int          gaps;
    logic [31:0] d;
    err = build_model(base, top);
    base_addr_i   = base;
    top_addr_i    = top;
    enable_i      = 1'b1;
    frame_start_i = 1'b1;
    step();
    frame_start_i = 1'b0;
    chk("cfg_err", cfg_err_o, err);
    if (err) begin
      repeat (4) begin
        chk("err_no_req", rd_req_o, 0);
        step();
      end
      return;
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      cyc = 0;
      while (!rd_req_o && cyc < 40) begin
        step();
        cyc++;
      end
      chk("req_seen", rd_req_o, 1);
      if (!rd_req_o) return;
      chk("rd_addr", rd_addr_o, exp_q[k].addr);
      chk("rd_len", rd_len_o, exp_q[k].len);
      delay = (gd >= 0) ? gd : int'($urandom_range(0, 3));
      for (int j = 0; j < delay; j++) begin
        frame_start_i = (k == 0) && (j < 2 * late) && (j % 2 == 0);
        if (frame_start_i && LATE_EN) exp_late++;
        step();
        frame_start_i = 1'b0;
        chk("hold_req", rd_req_o, 1);
        chk("hold_addr", rd_addr_o, exp_q[k].addr);
        chk("hold_len", rd_len_o, exp_q[k].len);
      end
      rd_gnt_i = 1'b1;
      step();
      rd_gnt_i = 1'b0;
      chk("req_drop", rd_req_o, 0);
      for (int unsigned i = 0; i <= exp_q[k].len; i++) begin
        gaps = int'($urandom_range(0, 2));
        repeat (gaps) begin
          rd_valid_i = 1'b0;
          #1;
          chk("gap_wr_en", wr_en_o, 0);
          step();
        end
        d = $urandom;
        rd_valid_i = 1'b1;
        rd_data_i  = d;
        rd_last_i  = (i == exp_q[k].len);
        #1;
        chk("wr_en", wr_en_o, 1);
        chk("wr_idx", wr_idx_o, i);
        chk("wr_bank", wr_bank_o, exp_bank);
        chk("wr_data", wr_data_o, d);
        step();
      end
      rd_valid_i = 1'b0;
      rd_last_i  = 1'b0;
      exp_full[exp_bank] = 1'b1;
      chk("bank_full_set", bank_full_o, exp_full);
      chk("frame_done", frame_done_o, (k == exp_q.size() - 1));
      exp_bank = ~exp_bank;
      if (norel && k == 0) begin
        // second bank still free, fetch continues unreleased
      end else if (norel && k == 1) begin
        repeat (6) begin
          step();
          chk("stall_no_req", rd_req_o, 0);
          chk("stall_full", bank_full_o, 2'b11);
        end
        buf_release_i = 2'b00;
        buf_release_i[exp_bank] = 1'b1;
        step();
        buf_release_i = 2'b00;
        exp_full[exp_bank] = 1'b0;
        chk("partial_release", bank_full_o, exp_full);
      end else begin
        buf_release_i = exp_full;
        step();
        buf_release_i = 2'b00;
        exp_full = 2'b00;
        chk("release", bank_full_o, 0);
        if (k == exp_q.size() - 1) chk("frame_done_pulse", frame_done_o, 0);
      end
    end
    chk("late_cnt", late_cnt_o, exp_late);
  endtask

  initial begin
    int          cyc;
    logic [31:0] base;
    logic [31:0] top;

    repeat (3) step();
    check_all_zero("reset");
    resetn = 1'b1;
    step();

    run_frame(32'h1000, 32'h1080, 1'b0, 5, 0);
    run_frame(32'h1000, 32'h1048, 1'b0, -1, 0);
    run_frame(32'h1000, 32'h1100, 1'b1, -1, 0);
    run_frame(32'h2000, 32'h2000, 1'b0, -1, 0);
    run_frame(32'h2000, 32'h2040, 1'b0, -1, 0);

    for (int f = 0; f < 6; f++) begin
      base = $urandom_range(32'h0010_0000, 32'h7000_0000) & 32'hFFFF_FFFC;
      if (f == 3) top = base + $urandom_range(0, 3);
      else        top = base + $urandom_range(1, 70) * 4 + $urandom_range(0, 3);
      run_frame(base, top, 1'b0, -1, 0);
    end

    // reset in the middle of a burst
    base_addr_i   = 32'h3000;
    top_addr_i    = 32'h3040;
    frame_start_i = 1'b1;
    step();
    frame_start_i = 1'b0;
    cyc = 0;
    while (!rd_req_o && cyc < 40) begin
      step();
      cyc++;
    end
    chk("rst_req_seen", rd_req_o, 1);
    rd_gnt_i = 1'b1;
    step();
    rd_gnt_i = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      rd_valid_i = 1'b1;
      rd_data_i  = $urandom;
      #1;
      chk("rst_wr_idx", wr_idx_o, i);
      chk("rst_wr_bank", wr_bank_o, exp_bank);
      step();
    end
    resetn = 1'b0;
    step();
    check_all_zero("mid_reset");
    resetn     = 1'b1;
    rd_valid_i = 1'b0;
    exp_bank   = 1'b0;
    exp_full   = 2'b00;
    exp_late   = 0;
    step();

    run_frame(32'h4000, 32'h4040, 1'b0, 5, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
